// File: rtl/sl_fifo_pkg.sv
// Shared word format, modifier codes and write-arbiter state encoding for the host-bound FIFO path.
package sl_fifo_pkg;

   localparam int unsigned WordW = 34;
   localparam int unsigned HMB   = 33;
   localparam int unsigned LMB   = 32;

   typedef enum logic [1:0] {
      ModConfig  = 2'd0,
      ModData    = 2'd1,
      ModStatus  = 2'd2,
      ModChannel = 2'd3
   } sl_mod_e;

   typedef enum logic [3:0] {
      StArb    = 4'b0001,
      StTag    = 4'b0010,
      StTagGap = 4'b0100,
      StData   = 4'b1000
   } sl_arb_state_e;

   // Tag word announcing that the following data words belong to source idx.
   function automatic logic [WordW-1:0] chan_tag(input int unsigned idx);
      logic [WordW-1:0] w;
      w          = '0;
      w[HMB:LMB] = ModChannel;
      w[LMB-1:0] = idx;
      return w;
   endfunction

endpackage

// File: rtl/sl_rr_pick.sv
// Combinational round-robin search: first set request at or after start, wrapping at N_REQ.
module sl_rr_pick #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IdxW-1:0]  start,
   output logic [IdxW-1:0]  winner,
   output logic             any
);

   logic [IdxW:0] j;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      j      = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         j = {1'b0, start} + (IdxW + 1)'(i);
         if (j >= (IdxW + 1)'(N_REQ)) begin
            j = j - (IdxW + 1)'(N_REQ);
         end
         if (!any && req[j[IdxW-1:0]]) begin
            any    = 1'b1;
            winner = j[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/sl_fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of the host FIFO write port among N_REQ word sources.
// Define SL_ARB_CHANNEL_TAG_EN to prefix a channel tag word whenever the owning source changes.
module sl_fifo_wr_arbiter
   import sl_fifo_pkg::*;
#(
   parameter int unsigned N_REQ     = 2,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [WordW*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     fifo_write_full,
   output logic [WordW-1:0]         fifo_write_data,
   output logic                     fifo_write_inc
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CntW = $clog2(MAX_BURST + 1);

   sl_arb_state_e   state_q;
   logic [IdxW-1:0] owner_q;
   logic [CntW-1:0] burst_q;
`ifdef SL_ARB_CHANNEL_TAG_EN
   logic            tag_valid_q;
   logic [WordW-1:0] owner_word;
`endif

   logic [IdxW-1:0]  start_idx, pick_idx, winner;
   logic             pick_any, others_valid, owner_cont;
   logic [N_REQ-1:0] own_mask, win_mask;
   logic [WordW-1:0] winner_word;
   logic [CntW-1:0]  burst_base;

   function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c);
      return (c == CntW'(MAX_BURST)) ? c : c + 1'b1;
   endfunction

   sl_rr_pick #(
      .N_REQ (N_REQ),
      .IdxW  (IdxW)
   ) u_pick (
      .req    (req_valid),
      .start  (start_idx),
      .winner (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      own_mask          = '0;
      own_mask[owner_q] = 1'b1;
      start_idx    = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
      others_valid = |(req_valid & ~own_mask);
      // The burst limit only bites while someone else is waiting.
      owner_cont   = req_valid[owner_q] && ((burst_q < CntW'(MAX_BURST)) || !others_valid);
      winner       = owner_cont ? owner_q : pick_idx;
      win_mask     = N_REQ'(1) << winner;
      winner_word  = req_data[32'(winner) * WordW +: WordW];
      burst_base   = ((winner != owner_q) || !others_valid) ? '0 : burst_q;
`ifdef SL_ARB_CHANNEL_TAG_EN
      owner_word   = req_data[32'(owner_q) * WordW +: WordW];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StArb;
         owner_q         <= '0;
         burst_q         <= '0;
`ifdef SL_ARB_CHANNEL_TAG_EN
         tag_valid_q     <= 1'b0;
`endif
         fifo_write_data <= '0;
         fifo_write_inc  <= 1'b0;
         req_ready       <= '0;
      end else begin
         fifo_write_inc <= 1'b0;
         req_ready      <= '0;
         unique case (state_q)
            StArb: begin
               if (!fifo_write_full && pick_any) begin
`ifdef SL_ARB_CHANNEL_TAG_EN
                  if ((winner != owner_q) || !tag_valid_q) begin
                     state_q         <= StTag;
                     owner_q         <= winner;
                     burst_q         <= '0;
                     tag_valid_q     <= 1'b1;
                     fifo_write_data <= chan_tag(32'(winner));
                     fifo_write_inc  <= 1'b1;
                  end else begin
                     state_q         <= StData;
                     burst_q         <= sat_inc(burst_base);
                     fifo_write_data <= winner_word;
                     fifo_write_inc  <= 1'b1;
                     req_ready       <= win_mask;
                  end
`else
                  state_q         <= StData;
                  owner_q         <= winner;
                  burst_q         <= sat_inc(burst_base);
                  fifo_write_data <= winner_word;
                  fifo_write_inc  <= 1'b1;
                  req_ready       <= win_mask;
`endif
               end
            end
`ifdef SL_ARB_CHANNEL_TAG_EN
            StTag: begin
               state_q <= StTagGap;
            end
            // Gap cycle lets the full flag reflect the tag write before the data word goes out.
            StTagGap: begin
               if (!fifo_write_full) begin
                  state_q         <= StData;
                  burst_q         <= sat_inc(burst_q);
                  fifo_write_data <= owner_word;
                  fifo_write_inc  <= 1'b1;
                  req_ready       <= own_mask;
               end
            end
`endif
            StData: begin
               state_q <= StArb;
            end
            default: begin
               state_q <= StArb;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sl_fifo_wr_arbiter.sv
// Scoreboard bench for sl_fifo_wr_arbiter: directed scenarios plus randomised rounds with random full.
// Follows SL_ARB_CHANNEL_TAG_EN to decide whether tag words are expected.
module tb_sl_fifo_wr_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned MB = 2;

   typedef logic [33:0] word_t;
   typedef struct packed {
      word_t         d;
      logic [NR-1:0] rdy;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [34*NR-1:0] req_data;
   logic            fifo_write_full;
   word_t           fifo_write_data;
   logic            fifo_write_inc;

   sl_fifo_wr_arbiter #(
      .N_REQ     (NR),
      .MAX_BURST (MB)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .fifo_write_full (fifo_write_full),
      .fifo_write_data (fifo_write_data),
      .fifo_write_inc  (fifo_write_inc)
   );

   int    total = 0;
   int    bad   = 0;
   word_t src_q [NR][$];
   exp_t  exp_q [$];
   word_t seen_q [$];
   word_t want_q [$];
   int    strobe_cnt = 0;
   int    ready_cnt [NR];
   bit    rand_full  = 1'b0;
   bit    full_force = 1'b0;
   int    m_owner    = 0;
   int    m_cnt      = 0;
   bit    m_tagged   = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   function automatic bit src_empty();
      for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int ready_sum();
      int s = 0;
      for (int i = 0; i < NR; i++) s += ready_cnt[i];
      return s;
   endfunction

   // Reference order: replay the arbitration rules over every word the sources hold.
   task automatic plan();
      word_t cp [NR][$];
      int    w, j;
      bit    any, others, found;
      for (int i = 0; i < NR; i++) cp[i] = src_q[i];
      while (1) begin
         any    = 1'b0;
         others = 1'b0;
         for (int i = 0; i < NR; i++) begin
            if (cp[i].size() > 0) begin
               any = 1'b1;
               if (i != m_owner) others = 1'b1;
            end
         end
         if (!any) break;
         w = m_owner;
         if (cp[m_owner].size() == 0 || (m_cnt >= MB && others)) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
               j = (m_owner + k) % NR;
               if (!found && cp[j].size() > 0) begin
                  found = 1'b1;
                  w     = j;
               end
            end
         end
         if (!others) m_cnt = 0;
`ifdef SL_ARB_CHANNEL_TAG_EN
         if (w != m_owner || !m_tagged) begin
            exp_q.push_back('{d: {2'd3, 32'(w)}, rdy: '0});
            m_tagged = 1'b1;
            m_cnt    = 0;
         end
`else
         if (w != m_owner) m_cnt = 0;
`endif
         m_owner = w;
         exp_q.push_back('{d: cp[w].pop_front(), rdy: NR'(1) << w});
         if (m_cnt < MB) m_cnt++;
      end
   endtask

   // Requesters: hold the head word until acked, then present the next one.
   initial begin
      req_valid       = '0;
      req_data        = '0;
      fifo_write_full = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         fifo_write_full = rand_full ? ($urandom_range(0, 2) == 0) : full_force;
         for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && req_valid[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               req_valid[i]          = 1'b1;
               req_data[34*i +: 34]  = src_q[i][0];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: every strobe must match the head of the scoreboard.
   initial begin
      bit   prev_inc;
      exp_t e;
      prev_inc = 1'b0;
      for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_inc = 1'b0;
         end else begin
            for (int i = 0; i < NR; i++) if (req_ready[i]) ready_cnt[i]++;
            if (fifo_write_inc) begin
               strobe_cnt++;
               seen_q.push_back(fifo_write_data);
               check("inc_back_to_back", prev_inc, 0);
               check("strobe_after_full", fifo_write_full, 0);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word: got %h, required no write", fifo_write_data);
               end else begin
                  e = exp_q.pop_front();
                  check("word", fifo_write_data, e.d);
                  check("ready_with_word", req_ready, e.rdy);
               end
            end else if (req_ready != '0) begin
               check("ready_without_strobe", req_ready, 0);
            end
            prev_inc = fifo_write_inc;
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_inc", fifo_write_inc, 0);
      check("rst_data", fifo_write_data, 0);
      check("rst_ready", req_ready, 0);
      exp_q.delete();
      m_owner  = 0;
      m_cnt    = 0;
      m_tagged = 1'b0;
      plan();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while ((exp_q.size() != 0 || !src_empty()) && c < budget) begin
         @(posedge clk);
         #2;
         c++;
      end
      total++;
      if (exp_q.size() != 0 || !src_empty()) begin
         bad++;
         $display("FAIL drain: %0d words still outstanding after %0d cycles, required 0",
                  exp_q.size(), budget);
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic check_stream(input string name);
      check({name, "_len"}, seen_q.size(), want_q.size());
      for (int i = 0; i < want_q.size() && i < seen_q.size(); i++) begin
         check($sformatf("%s_w%0d", name, i), seen_q[i], want_q[i]);
      end
   endtask

   task automatic wait_strobe(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(posedge clk);
         #2;
         if (fifo_write_inc) break;
      end
   endtask

   initial begin
      int snap_s, snap_r;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      do_reset();

      // Single requester: first word after reset is tagged.
      seen_q.delete();
      src_q[0].push_back(34'h1_00000011);
      src_q[0].push_back(34'h1_00000022);
      plan();
      drain(100);
      check("single_acks", ready_cnt[0], 2);
      want_q.delete();
`ifdef SL_ARB_CHANNEL_TAG_EN
      want_q.push_back(34'h3_00000000);
`endif
      want_q.push_back(34'h1_00000011);
      want_q.push_back(34'h1_00000022);
      check_stream("single");

      // Two requesters, three words each, burst limit 2.
      do_reset();
      seen_q.delete();
      src_q[0].push_back(34'h1_000000A0);
      src_q[0].push_back(34'h3_000000A1);
      src_q[0].push_back(34'h1_000000A2);
      src_q[1].push_back(34'h2_000000B0);
      src_q[1].push_back(34'h0_000000B1);
      src_q[1].push_back(34'h1_000000B2);
      plan();
      drain(200);
      want_q.delete();
`ifdef SL_ARB_CHANNEL_TAG_EN
      want_q = '{34'h3_00000000, 34'h1_000000A0, 34'h3_000000A1, 34'h3_00000001,
                 34'h2_000000B0, 34'h0_000000B1, 34'h3_00000000, 34'h1_000000A2,
                 34'h3_00000001, 34'h1_000000B2};
`else
      want_q = '{34'h1_000000A0, 34'h3_000000A1, 34'h2_000000B0, 34'h0_000000B1,
                 34'h1_000000A2, 34'h1_000000B2};
`endif
      check_stream("two_req");

      // Backpressure: requester 1 still owns, so no tag on release.
      full_force = 1'b1;
      @(posedge clk);
      #2;
      snap_s = strobe_cnt;
      snap_r = ready_sum();
      src_q[1].push_back(34'h1_000000C0);
      src_q[1].push_back(34'h1_000000C1);
      plan();
      repeat (10) begin
         @(posedge clk);
         #2;
      end
      check("bp_no_strobe", strobe_cnt, snap_s);
      check("bp_no_ready", ready_sum(), snap_r);
      full_force = 1'b0;
      @(posedge clk);
      #2;
      check("bp_release_inc", fifo_write_inc, 1);
      check("bp_release_data", fifo_write_data, 34'h1_000000C0);
      drain(100);

`ifdef SL_ARB_CHANNEL_TAG_EN
      // Full raised during the gap after a tag: no repeat tag, data once.
      seen_q.delete();
      src_q[0].push_back(34'h1_000000D0);
      plan();
      wait_strobe(20);
      check("gap_tag_inc", fifo_write_inc, 1);
      check("gap_tag_data", fifo_write_data, 34'h3_00000000);
      @(posedge clk);
      #2;
      full_force = 1'b1;
      snap_s     = strobe_cnt;
      repeat (5) begin
         @(posedge clk);
         #2;
      end
      check("gap_stall", strobe_cnt, snap_s);
      full_force = 1'b0;
      drain(100);
      want_q = '{34'h3_00000000, 34'h1_000000D0};
      check_stream("gap");

      // Reset while in the tag gap: interrupted word re-sent after a fresh tag.
      src_q[1].push_back(34'h2_000000E0);
      src_q[1].push_back(34'h1_000000E1);
      plan();
      wait_strobe(20);
      check("rst_tag_data", fifo_write_data, 34'h3_00000001);
      @(posedge clk);
      #2;
      snap_r = ready_cnt[1];
      seen_q.delete();
      do_reset();
      drain(100);
      want_q = '{34'h3_00000001, 34'h2_000000E0, 34'h1_000000E1};
      check_stream("rst_mid");
      check("rst_mid_acks", ready_cnt[1] - snap_r, 2);
`endif

      // Randomised rounds with random full.
      rand_full = 1'b1;
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < NR; i++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) src_q[i].push_back({2'($urandom), 32'($urandom)});
         end
         plan();
         drain(800);
      end
      rand_full = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
